// File: rtl/adpll_acq_ctrl.sv
// ---------------------------------------------------------------------------
// adpll_acq_ctrl
//
// Acquisition and lock controller for the ADPLL loop (ID_clk domain).
// Counts synchronized up/down pulses from the phase-detector interface over
// fixed windows and gear-shifts the PI filter from coarse gains to fine gains
// and finally to a declared lock. Loses lock (back to coarse) on a noisy
// window, and flags a timeout if coarse acquisition takes too long.
//
// Ports:
//   clk          in   ID_clk domain clock
//   rst          in   synchronous, active-low reset
//   enable       in   loop run request (level)
//   up_pulse     in   single-cycle up pulse from the PFD interface
//   down_pulse   in   single-cycle down pulse from the PFD interface
//   p_gain       out  proportional gain to the PI filter   [GAIN_W]
//   i_gain       out  integral gain to the PI filter       [GAIN_W]
//   filter_hold  out  1 = PI filter freezes its integrator
//   locked       out  lock status (level)
//   lock_lost    out  one-cycle pulse when a declared lock drops
//   acq_timeout  out  one-cycle pulse when coarse acquisition times out
//   state        out  IDLE=0, COARSE=1, FINE=2, LOCKED=3
// ---------------------------------------------------------------------------
module adpll_acq_ctrl #(
    parameter int WINDOW_LEN  = 1024,
    parameter int PCW         = 8,
    parameter int GAIN_W      = 4,
    parameter int COARSE_P    = 4,
    parameter int COARSE_I    = 2,
    parameter int FINE_P      = 1,
    parameter int FINE_I      = 1,
    parameter int QUIET_MAX   = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_MAX  = 32,
    parameter int ACQ_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              up_pulse,
    input  logic              down_pulse,
    output logic [GAIN_W-1:0] p_gain,
    output logic [GAIN_W-1:0] i_gain,
    output logic              filter_hold,
    output logic              locked,
    output logic              lock_lost,
    output logic              acq_timeout,
    output logic [1:0]        state
);

    localparam int WW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [WW-1:0]     WLAST     = WW'(WINDOW_LEN - 1);
    localparam logic [PCW-1:0]    PCNT_MAX  = {PCW{1'b1}};
    localparam logic [PCW:0]      PSUM_MAX  = {1'b0, {PCW{1'b1}}};
    localparam logic [PCW-1:0]    QUIET_TH  = PCW'(QUIET_MAX);
    localparam logic [PCW-1:0]    UNLOCK_TH = PCW'(UNLOCK_MAX);
    localparam logic [GW-1:0]     LOCK_TH   = GW'(LOCK_COUNT);
    localparam logic [TW-1:0]     TMO_TH    = TW'(ACQ_TIMEOUT);
    localparam logic [GAIN_W-1:0] CP        = GAIN_W'(COARSE_P);
    localparam logic [GAIN_W-1:0] CI        = GAIN_W'(COARSE_I);
    localparam logic [GAIN_W-1:0] FP        = GAIN_W'(FINE_P);
    localparam logic [GAIN_W-1:0] FI        = GAIN_W'(FINE_I);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;
    logic [WW-1:0]   wcnt;
    logic [WW-1:0]   wcnt_nxt;
    logic [PCW-1:0]  pcnt;
    logic [PCW-1:0]  pcnt_nxt;
    logic [GW-1:0]   good;
    logic [GW-1:0]   good_nxt;
    logic [TW-1:0]   tcnt;
    logic [TW-1:0]   tcnt_nxt;

    logic [1:0]        pulse_inc;
    logic [PCW:0]      pcnt_sum;
    logic [PCW-1:0]    pcnt_eval;
    logic              win_end;
    logic              quiet;
    logic              unlock;
    logic [GW-1:0]     good_inc;
    logic              good_hit;
    logic [TW-1:0]     tcnt_inc;
    logic              timeout_hit;

    logic [GAIN_W-1:0] p_gain_nxt;
    logic [GAIN_W-1:0] i_gain_nxt;
    logic              filter_hold_nxt;
    logic              locked_nxt;
    logic              lock_lost_nxt;
    logic              acq_timeout_nxt;

    assign state = cur_state;

    // Window bookkeeping: the evaluated count includes this cycle's pulses so
    // a pulse landing on the last window cycle is not lost. The sum is one bit
    // wider than the counter so saturation can be detected without wrapping.
    always_comb begin
        pulse_inc   = {1'b0, up_pulse} + {1'b0, down_pulse};
        pcnt_sum    = {1'b0, pcnt} + (PCW + 1)'(pulse_inc);
        pcnt_eval   = (pcnt_sum > PSUM_MAX) ? PCNT_MAX : pcnt_sum[PCW-1:0];
        win_end     = (cur_state != ST_IDLE) && (wcnt == WLAST);
        quiet       = (pcnt_eval <= QUIET_TH);
        unlock      = (pcnt_eval > UNLOCK_TH);
        good_inc    = (good >= LOCK_TH) ? LOCK_TH : good + 1'b1;
        good_hit    = (good_inc >= LOCK_TH);
        tcnt_inc    = (tcnt >= TMO_TH) ? TMO_TH : tcnt + 1'b1;
        timeout_hit = (tcnt_inc >= TMO_TH);
    end

    // Next-state and next-output logic. Window-end decisions are made first,
    // then disable overrides them, and finally any state change restarts all
    // counters so the next window begins cleanly on the cycle after entry.
    always_comb begin
        nxt_state       = cur_state;
        wcnt_nxt        = (wcnt == WLAST) ? '0 : wcnt + 1'b1;
        pcnt_nxt        = win_end ? '0 : pcnt_eval;
        good_nxt        = good;
        tcnt_nxt        = tcnt;
        lock_lost_nxt   = 1'b0;
        acq_timeout_nxt = 1'b0;

        case (cur_state)
            ST_IDLE: begin
                wcnt_nxt = '0;
                pcnt_nxt = '0;
                good_nxt = '0;
                tcnt_nxt = '0;
                if (enable) begin
                    nxt_state = ST_COARSE;
                end
            end
            ST_COARSE: begin
                if (win_end) begin
                    good_nxt = quiet ? good_inc : '0;
                    tcnt_nxt = tcnt_inc;
                    // An advance on the same window end as a timeout wins.
                    if (quiet && good_hit) begin
                        nxt_state = ST_FINE;
                    end else if (timeout_hit) begin
                        acq_timeout_nxt = 1'b1;
                        good_nxt        = '0;
                        tcnt_nxt        = '0;
                    end
                end
            end
            ST_FINE: begin
                if (win_end) begin
                    if (unlock) begin
                        nxt_state = ST_COARSE;
                    end else if (quiet) begin
                        good_nxt = good_inc;
                        if (good_hit) begin
                            nxt_state = ST_LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (win_end && unlock) begin
                    nxt_state     = ST_COARSE;
                    lock_lost_nxt = 1'b1;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        // Dropping enable is a deliberate shutdown, not a lock loss.
        if ((cur_state != ST_IDLE) && !enable) begin
            nxt_state       = ST_IDLE;
            lock_lost_nxt   = 1'b0;
            acq_timeout_nxt = 1'b0;
        end

        if (nxt_state != cur_state) begin
            wcnt_nxt = '0;
            pcnt_nxt = '0;
            good_nxt = '0;
            tcnt_nxt = '0;
        end
    end

    // Output decode from the next state so gains, hold and locked switch on
    // the same edge as the state itself.
    always_comb begin
        p_gain_nxt      = '0;
        i_gain_nxt      = '0;
        filter_hold_nxt = 1'b1;
        locked_nxt      = 1'b0;
        case (nxt_state)
            ST_COARSE: begin
                p_gain_nxt      = CP;
                i_gain_nxt      = CI;
                filter_hold_nxt = 1'b0;
            end
            ST_FINE: begin
                p_gain_nxt      = FP;
                i_gain_nxt      = FI;
                filter_hold_nxt = 1'b0;
            end
            ST_LOCKED: begin
                p_gain_nxt      = FP;
                i_gain_nxt      = FI;
                filter_hold_nxt = 1'b0;
                locked_nxt      = 1'b1;
            end
            default: begin
                p_gain_nxt      = '0;
                i_gain_nxt      = '0;
                filter_hold_nxt = 1'b1;
                locked_nxt      = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs are registered; reset wins over any
    // in-progress window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state   <= ST_IDLE;
            wcnt        <= '0;
            pcnt        <= '0;
            good        <= '0;
            tcnt        <= '0;
            p_gain      <= '0;
            i_gain      <= '0;
            filter_hold <= 1'b1;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            acq_timeout <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            wcnt        <= wcnt_nxt;
            pcnt        <= pcnt_nxt;
            good        <= good_nxt;
            tcnt        <= tcnt_nxt;
            p_gain      <= p_gain_nxt;
            i_gain      <= i_gain_nxt;
            filter_hold <= filter_hold_nxt;
            locked      <= locked_nxt;
            lock_lost   <= lock_lost_nxt;
            acq_timeout <= acq_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_adpll_acq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adpll_acq_ctrl
//
// Self-checking bench for adpll_acq_ctrl with a small window configuration.
// A behavioural model tracks the acquisition phase, window position and
// per-window pulse totals; every cycle the DUT outputs are compared with it.
// Directed windows with hand-computed outcomes pin both model and DUT.
// ---------------------------------------------------------------------------
module tb_adpll_acq_ctrl;

    localparam int WL = 16;
    localparam int LC = 2;
    localparam int QM = 2;
    localparam int UM = 6;
    localparam int AT = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       up_pulse;
    logic       down_pulse;
    logic [3:0] p_gain;
    logic [3:0] i_gain;
    logic       filter_hold;
    logic       locked;
    logic       lock_lost;
    logic       acq_timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // model state
    int m_phase = 0;
    int m_pos   = 0;
    int m_count = 0;
    int m_good  = 0;
    int m_wins  = 0;
    int cyc     = 0;
    bit m_lost  = 0;
    bit m_tmo   = 0;

    adpll_acq_ctrl #(
        .WINDOW_LEN (WL),
        .PCW        (8),
        .GAIN_W     (4),
        .COARSE_P   (4),
        .COARSE_I   (2),
        .FINE_P     (1),
        .FINE_I     (1),
        .QUIET_MAX  (QM),
        .LOCK_COUNT (LC),
        .UNLOCK_MAX (UM),
        .ACQ_TIMEOUT(AT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .p_gain     (p_gain),
        .i_gain     (i_gain),
        .filter_hold(filter_hold),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .acq_timeout(acq_timeout),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic m_enter(input int ph);
        m_phase = ph;
        m_pos   = 0;
        m_count = 0;
        m_good  = 0;
        m_wins  = 0;
    endtask

    task automatic m_window_end(input int c);
        m_pos   = 0;
        m_count = 0;
        case (m_phase)
            1: begin
                m_wins++;
                if (c <= QM) m_good++; else m_good = 0;
                if (m_good >= LC) m_enter(2);
                else if (m_wins >= AT) begin
                    m_tmo  = 1;
                    m_good = 0;
                    m_wins = 0;
                end
            end
            2: begin
                if (c > UM) m_enter(1);
                else if (c <= QM) begin
                    m_good++;
                    if (m_good >= LC) m_enter(3);
                end else m_good = 0;
            end
            3: begin
                if (c > UM) begin
                    m_enter(1);
                    m_lost = 1;
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        cyc++;
        m_lost = 0;
        m_tmo  = 0;
        if (!rst) m_enter(0);
        else if (m_phase == 0) begin
            if (enable) m_enter(1);
        end else if (!enable) m_enter(0);
        else begin
            m_count = m_count + int'(up_pulse) + int'(down_pulse);
            if (m_count > 255) m_count = 255;
            if (m_pos < WL - 1) m_pos++;
            else m_window_end(m_count);
        end
    end

    function automatic logic [31:0] model_full();
        int p;
        int i;
        p = (m_phase == 1) ? 4 : (m_phase >= 2) ? 1 : 0;
        i = (m_phase == 1) ? 2 : (m_phase >= 2) ? 1 : 0;
        return {18'd0, m_phase[1:0], p[3:0], i[3:0], (m_phase == 0), (m_phase == 3), m_lost, m_tmo};
    endfunction

    function automatic logic [31:0] dut_full();
        return {18'd0, state, p_gain, i_gain, filter_hold, locked, lock_lost, acq_timeout};
    endfunction

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (checking) checkOutput("cycle", dut_full(), model_full());
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic r, input logic en, input logic u, input logic d);
        @(negedge clk);
        rst        = r;
        enable     = en;
        up_pulse   = u;
        down_pulse = d;
        @(posedge clk);
        #1;
    endtask

    // One aligned window: n single up pulses at the start, optionally up and
    // down together on the last cycle.
    task automatic driveWindow(input int n, input bit both_at_end);
        for (int k = 0; k < WL; k++) begin
            if (both_at_end && k == WL - 1) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
            else applyStimulus(1'b1, 1'b1, (k < n), 1'b0);
        end
    endtask

    // Literal pin: {state, p_gain, locked, lock_lost, acq_timeout} on DUT and model.
    task automatic pin(input string name, input int st, input int p, input int lk, input int ll, input int to);
        logic [8:0] exp_v;
        logic [8:0] dut_v;
        logic [8:0] mod_v;
        logic [31:0] mf;
        exp_v = {st[1:0], p[3:0], lk[0], ll[0], to[0]};
        dut_v = {state, p_gain, locked, lock_lost, acq_timeout};
        mf    = model_full();
        mod_v = {mf[13:12], mf[11:8], mf[2], mf[1], mf[0]};
        checkOutput({name, "_dut"}, 32'(dut_v), 32'(exp_v));
        checkOutput({name, "_model"}, 32'(mod_v), 32'(exp_v));
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; up_pulse = 1'b0; down_pulse = 1'b0;

        // reset with enable and toggling pulses
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checking = 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        pin("reset", 0, 0, 0, 0, 0);
        checkOutput("reset_hold", 32'(filter_hold), 32'd1);

        // clean acquisition: 1 + 32 + 32 = 65 edges to lock
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pin("enter_coarse", 1, 4, 0, 0, 0);
        checkOutput("coarse_i", 32'(i_gain), 32'd2);
        driveWindow(0, 0);
        pin("coarse_w1", 1, 4, 0, 0, 0);
        driveWindow(0, 0);
        pin("enter_fine", 2, 1, 0, 0, 0);
        driveWindow(0, 0);
        driveWindow(0, 0);
        pin("locked_65", 3, 1, 1, 0, 0);

        // lock loss: 7 pulses in one window
        driveWindow(7, 0);
        pin("lock_lost", 1, 4, 0, 1, 0);

        // boundary counts in FINE
        driveWindow(0, 0);
        driveWindow(0, 0);
        pin("fine_again", 2, 1, 0, 0, 0);
        driveWindow(0, 1);
        pin("fine_q2", 2, 1, 0, 0, 0);
        driveWindow(3, 0);
        pin("fine_3p", 2, 1, 0, 0, 0);
        driveWindow(0, 1);
        pin("fine_delay", 2, 1, 0, 0, 0);
        driveWindow(1, 0);
        pin("lock_after_delay", 3, 1, 1, 0, 0);

        // timeout in COARSE
        driveWindow(7, 0);
        pin("lost_again", 1, 4, 0, 1, 0);
        for (int w = 1; w <= 8; w++) begin
            driveWindow(5, 0);
            if (w == 4 || w == 8) pin($sformatf("tmo_w%0d", w), 1, 4, 0, 0, 1);
            if (w == 3 || w == 7) pin($sformatf("notmo_w%0d", w), 1, 4, 0, 0, 0);
        end
        // timeout coincides with advance: advance wins
        driveWindow(5, 0);
        driveWindow(5, 0);
        driveWindow(0, 0);
        pin("pre_advance", 1, 4, 0, 0, 0);
        driveWindow(0, 0);
        pin("advance_wins", 2, 1, 0, 0, 0);

        // disable while locked
        driveWindow(0, 0);
        driveWindow(0, 0);
        pin("relocked", 3, 1, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        pin("disabled", 0, 0, 0, 0, 0);
        checkOutput("disabled_hold", 32'(filter_hold), 32'd1);

        // reset mid-window in FINE
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        driveWindow(0, 0);
        driveWindow(0, 0);
        pin("fine_before_rst", 2, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        pin("midwin_reset", 0, 0, 0, 0, 0);
        checkOutput("midwin_reset_i", 32'(i_gain), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pin("idle_end", 0, 0, 0, 0, 0);

        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/adpll_acq_ctrl.md
# adpll_acq_ctrl

Acquisition and lock controller for the ADPLL loop. It watches the synchronized up/down pulses from the phase-detector interface and counts them over fixed windows. From those counts it runs a gear-shift sequence: coarse loop gains first, then fine gains, then a declared lock. It drives the PI filter gain and hold controls plus lock status, and sits between the PFD interface and the PI filter in the ID_clk domain.

## Interface
- WINDOW_LEN, 1024: window length in clk cycles (≥4).
- PCW, 8: pulse-counter width; counter saturates at 2^PCW−1.
- GAIN_W, 4: width of gain outputs.
- COARSE_P / COARSE_I, 4 / 2: gains driven in COARSE.
- FINE_P / FINE_I, 1 / 1: gains driven in FINE and LOCKED.
- QUIET_MAX, 8: max pulses per window for a window to count as "quiet".
- LOCK_COUNT, 4: consecutive quiet windows needed to advance a gear.
- UNLOCK_MAX, 32: pulses per window above which lock is lost.
- ACQ_TIMEOUT, 64: windows allowed in COARSE before a timeout.
- clk, input, 1: ID_clk domain clock.
- rst, input, 1: synchronous, active-low reset.
- enable, input, 1: loop run request, level.
- up_pulse, input, 1: single-cycle up pulse from the PFD interface.
- down_pulse, input, 1: single-cycle down pulse from the PFD interface.
- p_gain, output, GAIN_W: proportional gain to the PI filter.
- i_gain, output, GAIN_W: integral gain to the PI filter.
- filter_hold, output, 1: 1 = PI filter freezes its integrator.
- locked, output, 1: lock status, level.
- lock_lost, output, 1: one-cycle pulse when lock drops.
- acq_timeout, output, 1: one-cycle pulse when COARSE acquisition times out.
- state, output, 2: IDLE=0, COARSE=1, FINE=2, LOCKED=3.

## Operation
- Reset happens when rst==0 at a clk edge. All outputs and registers go to: state IDLE, p_gain=0, i_gain=0, filter_hold=1, locked=0, lock_lost=0, acq_timeout=0. The window counter, pulse counter, good counter and timeout counter all clear to 0.
- Reset overrides everything, including an in-progress window.
- Window counter wcnt:
  - Runs 0..WINDOW_LEN−1 in every state except IDLE.
  - It is held at 0 in IDLE and on every state change.
- Pulse counter pcnt:
  - Adds up_pulse + down_pulse each cycle, so it adds 2 when both are high.
  - It saturates and never wraps.
- Window end is the cycle where wcnt==WINDOW_LEN−1.
  - Evaluation uses pcnt including that cycle's pulses.
  - wcnt and pcnt both clear on the following cycle.
- A window is quiet when the evaluated count ≤ QUIET_MAX.
  - Each quiet window increments good (saturating).
  - Any non-quiet window clears good.
- IDLE:
  - Gains are 0 and filter_hold=1.
  - enable=1 → COARSE.
- COARSE:
  - Gains are COARSE_P/COARSE_I and filter_hold=0.
  - good reaches LOCK_COUNT at a window end → FINE, and good clears.
  - ACQ_TIMEOUT windows elapse without advancing → acq_timeout pulse, stay in COARSE, clear good and the timeout count.
- FINE:
  - Gains are FINE_P/FINE_I.
  - good reaches LOCK_COUNT → LOCKED, locked=1.
  - A window count > UNLOCK_MAX → COARSE. No lock_lost pulse in this case, since lock was never declared.
- LOCKED:
  - Gains are FINE and locked=1.
  - A window count > UNLOCK_MAX → lock_lost pulse, locked=0, → COARSE.
  - Quiet windows are ignored.
- enable=0 in any non-IDLE state → IDLE on the next edge.
  - locked=0, gains=0, filter_hold=1, counters clear.
  - No lock_lost pulse is issued on this path.
- Simultaneous events:
  - enable=0 beats any window-end decision.
  - A timeout and a LOCK_COUNT advance in the same window end → advance wins, no acq_timeout.
- If UNLOCK_MAX < QUIET_MAX, it is treated as-is; no check is required.

## Timing
- All outputs are registered.
- State, gains, hold and locked change on the same edge as the state transition.
- Latencies:
  - enable rising, sampled at edge N → state=COARSE and gains valid after edge N.
  - Window-end evaluation at edge N → new state visible after edge N.
  - lock_lost and acq_timeout are high for exactly the cycle after edge N.
- First window after entering COARSE/FINE/LOCKED starts with wcnt=0 on the cycle after entry.
- Minimum time to lock from enable is 2·LOCK_COUNT·WINDOW_LEN + 1 cycles.

## Test plan
All scenarios use WINDOW_LEN=16, LOCK_COUNT=2, QUIET_MAX=2, UNLOCK_MAX=6, ACQ_TIMEOUT=4.

- Reset: hold rst=0 for 3 cycles with enable=1 and pulses toggling → state=0, p_gain=0, i_gain=0, filter_hold=1, locked=0, no pulses on lock_lost or acq_timeout.
- Clean acquisition: enable=1, no pulses → COARSE (p=4, i=2) for 32 cycles, then FINE (p=1, i=1) for 32 cycles, then locked=1 and state=3 at cycle 65.
- Boundary count: in FINE, send exactly 2 pulses per window, including up and down together on the last window cycle → counted quiet, lock reached. Then send 3 pulses in one window → good clears and lock is delayed by 2 windows.
- Lock loss: in LOCKED, send 7 pulses in one window → a one-cycle lock_lost pulse after the window end, locked=0, state=1, gains return to 4/2.
- Timeout: in COARSE, send 5 pulses per window for 4 windows → acq_timeout pulses once after the 4th window end, state stays 1, and the pattern repeats every 4 windows.
- Disable and reset mid-operation: enable=0 while LOCKED → IDLE next edge, filter_hold=1, no lock_lost. Then enable=1 and assert rst=0 mid-window in FINE → all reset values next edge.
